// File: rtl/sobel_pkg.sv
// Shared widths and saturation helper for the Sobel edge-magnitude stream.
package sobel_pkg;

  // Extra bits above the pixel width: a 1,2,1 column sum reaches 4*max,
  // so the signed difference needs sign + 2 bits of growth.
  localparam int GRAD_EXTRA_W = 3;
  // |Gx|+|Gy| can reach 8*max, so the unsigned magnitude needs 3 extra bits.
  // One spare bit keeps the sum comfortably clear of wrap.
  localparam int MAG_EXTRA_W  = 4;
  localparam int SAT_IN_W     = 32;

  // Clamp an unsigned magnitude to the largest value representable in pix_w bits.
  function automatic logic [SAT_IN_W-1:0] sat_mag(input logic [SAT_IN_W-1:0] mag,
                                                  input int pix_w);
    logic [SAT_IN_W-1:0] lim;
    lim = (SAT_IN_W'(1) << pix_w) - SAT_IN_W'(1);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel stream in, edge-magnitude stream out, plus per-frame configuration.
interface sobel_stream_if #(
  parameter int PIX_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_last;
  logic             mode_max;
  logic             thr_en;
  logic [PIX_W-1:0] thr;

  // Environment side: supplies pixels and configuration, consumes results.
  modport master (
    output s_valid, s_data, m_ready, mode_max, thr_en, thr,
    input  s_ready, m_valid, m_data, m_last
  );

  // Filter side.
  modport slave (
    input  s_valid, s_data, m_ready, mode_max, thr_en, thr,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// One image line of storage: asynchronous read returns the old word at addr,
// the write of the same address lands on the clock edge (read-before-write).
module sobel_line_buffer #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  // Contents are never reset; every word is rewritten before it is consumed.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge magnitude over a raster-order pixel stream.
// Stages: p0 accept/window, p1 gradients, p2 magnitude/output register.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int PIX_W = 8
) (
  input logic         clk,
  input logic         rst,
  sobel_stream_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + GRAD_EXTRA_W;
  localparam int MW = PIX_W + MAG_EXTRA_W;

  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0]    COL_TWO  = CW'(2);
  localparam logic [RW-1:0]    ROW_TWO  = RW'(2);
  localparam logic [PIX_W-1:0] PIX_MAX  = '1;

  function automatic logic signed [GW-1:0] ext_pix(input logic [PIX_W-1:0] p);
    return signed'({{GRAD_EXTRA_W{1'b0}}, p});
  endfunction

  function automatic logic [MW-1:0] abs_grad(input logic signed [GW-1:0] g);
    logic signed [GW-1:0] n;
    n = g[GW-1] ? -g : g;
    return MW'(unsigned'(n));
  endfunction

  function automatic logic [PIX_W-1:0] sat_pix(input logic [MW-1:0] m);
    logic [SAT_IN_W-1:0] s;
    s = sat_mag(SAT_IN_W'(m), PIX_W);
    return s[PIX_W-1:0];
  endfunction

  logic stall, accept;

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             mode_q, mode_d;
  logic             thr_en_q, thr_en_d;
  logic [PIX_W-1:0] thr_q, thr_d;

  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic             vld_p0_q, vld_p0_d;
  logic             last_p0_q, last_p0_d;

  logic signed [GW-1:0] gx_p1_q, gx_p1_d;
  logic signed [GW-1:0] gy_p1_q, gy_p1_d;
  logic                 vld_p1_q, vld_p1_d;
  logic                 last_p1_q, last_p1_d;
  logic                 mode_p1_q, mode_p1_d;
  logic                 thr_en_p1_q, thr_en_p1_d;
  logic [PIX_W-1:0]     thr_p1_q, thr_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic             last_p2_q, last_p2_d;
  logic [PIX_W-1:0] data_p2_q, data_p2_d;

  // A held output blocks the whole pipeline; everything advances together.
  assign stall       = vld_p2_q && !bus.m_ready;
  assign accept      = bus.s_valid && !stall;
  assign bus.s_ready = !stall;
  assign bus.m_valid = vld_p2_q;
  assign bus.m_last  = last_p2_q;
  assign bus.m_data  = data_p2_q;

  // lb0 holds the previous line, lb1 the line before it.
  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_W(PIX_W)) u_lb0 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(bus.s_data), .rdata(lb0_rd)
  );
  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_W(PIX_W)) u_lb1 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  // Raster counters and frame-latched configuration.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    mode_d   = mode_q;
    thr_en_d = thr_en_q;
    thr_d    = thr_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (col_q == '0 && row_q == '0) begin
        mode_d   = bus.mode_max;
        thr_en_d = bus.thr_en;
        thr_d    = bus.thr;
      end
    end
  end

  // --- p0: window shift on accept; only interior centres are marked valid.
  always_comb begin
    win_d     = win_q;
    vld_p0_d  = stall ? vld_p0_q : 1'b0;
    last_p0_d = stall ? last_p0_q : 1'b0;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = bus.s_data;
      vld_p0_d    = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
      last_p0_d   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end
  end

  // --- p1: gradients. Config is picked up here because a new frame's first
  // accept always coincides with the previous frame's last pixel leaving p0.
  always_comb begin
    gx_p1_d     = gx_p1_q;
    gy_p1_d     = gy_p1_q;
    vld_p1_d    = vld_p1_q;
    last_p1_d   = last_p1_q;
    mode_p1_d   = mode_p1_q;
    thr_en_p1_d = thr_en_p1_q;
    thr_p1_d    = thr_p1_q;
    if (!stall) begin
      gx_p1_d = (ext_pix(win_q[0][2]) + (ext_pix(win_q[1][2]) <<< 1) + ext_pix(win_q[2][2]))
              - (ext_pix(win_q[0][0]) + (ext_pix(win_q[1][0]) <<< 1) + ext_pix(win_q[2][0]));
      gy_p1_d = (ext_pix(win_q[2][0]) + (ext_pix(win_q[2][1]) <<< 1) + ext_pix(win_q[2][2]))
              - (ext_pix(win_q[0][0]) + (ext_pix(win_q[0][1]) <<< 1) + ext_pix(win_q[0][2]));
      vld_p1_d    = vld_p0_q;
      last_p1_d   = last_p0_q;
      mode_p1_d   = mode_q;
      thr_en_p1_d = thr_en_q;
      thr_p1_d    = thr_q;
    end
  end

  // --- p2: magnitude, saturation, optional binarisation into the output register.
  always_comb begin
    logic [MW-1:0]    ax, ay, mag;
    logic [PIX_W-1:0] sat;
    ax        = abs_grad(gx_p1_q);
    ay        = abs_grad(gy_p1_q);
    mag       = mode_p1_q ? ((ax > ay) ? ax : ay) : (ax + ay);
    sat       = sat_pix(mag);
    vld_p2_d  = vld_p2_q;
    last_p2_d = last_p2_q;
    data_p2_d = data_p2_q;
    if (!stall) begin
      vld_p2_d  = vld_p1_q;
      last_p2_d = vld_p1_q && last_p1_q;
      if (vld_p1_q) begin
        data_p2_d = thr_en_p1_q ? ((sat >= thr_p1_q) ? PIX_MAX : '0) : sat;
      end
    end
  end

  // Control state and output register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= 1'b0;
      thr_en_q  <= 1'b0;
      thr_q     <= '0;
      vld_p0_q  <= 1'b0;
      last_p0_q <= 1'b0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      data_p2_q <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      mode_q    <= mode_d;
      thr_en_q  <= thr_en_d;
      thr_q     <= thr_d;
      vld_p0_q  <= vld_p0_d;
      last_p0_q <= last_p0_d;
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      vld_p2_q  <= vld_p2_d;
      last_p2_q <= last_p2_d;
      data_p2_q <= data_p2_d;
    end
  end

  // Datapath registers carry no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    win_q       <= win_d;
    gx_p1_q     <= gx_p1_d;
    gy_p1_q     <= gy_p1_d;
    mode_p1_q   <= mode_p1_d;
    thr_en_p1_q <= thr_en_p1_d;
    thr_p1_q    <= thr_p1_d;
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream with a frame-level reference model.
`timescale 1ns/1ps
module tb_sobel_stream;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int PW   = 8;
  localparam int NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_stream_if #(.PIX_W(PW)) bus ();

  sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int         errors = 0;
  int         checks = 0;
  int         img [H][W];
  logic [8:0] exp_q [$];
  logic [7:0] dut_log [$];
  int         out_cnt = 0;
  int         last_cnt = 0;
  int         cyc = 0;
  int         acc22_cyc = 0;
  bit         ignore_out = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: every interior centre, raster order, straight from the image.
  function automatic void model_frame(input bit mode, input bit ten, input int th);
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        int gx, gy, ax, ay, mag, wt;
        gx = 0; gy = 0;
        for (int d = -1; d <= 1; d++) begin
          wt = (d == 0) ? 2 : 1;
          gx += wt * (img[r + d][c + 1] - img[r + d][c - 1]);
          gy += wt * (img[r + 1][c + d] - img[r - 1][c + d]);
        end
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = mode ? ((ax > ay) ? ax : ay) : ax + ay;
        if (mag > 255) mag = 255;
        if (ten) mag = (mag >= th) ? 255 : 0;
        exp_q.push_back({(r == H - 2 && c == W - 2) ? 1'b1 : 1'b0, 8'(mag)});
      end
    end
  endfunction

  // Output checker: every handshake is compared against the model queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !ignore_out) begin
        if (bus.m_last && !bus.m_valid) chk("last_without_valid", 1, 0);
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", int'(bus.m_data), -1);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk("out_data", int'(bus.m_data), int'(e[7:0]));
            chk("out_last", int'(bus.m_last), int'(e[8]));
          end
          dut_log.push_back(bus.m_data);
          out_cnt++;
          if (bus.m_last) last_cnt++;
        end
      end
    end
  end

  task automatic push_pix(input int d);
    bus.s_valid = 1'b1;
    bus.s_data  = d[7:0];
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL push_timeout: s_ready stuck low, required 1");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "input handshake timed out");
  endtask

  // Config is presented for pixel (0,0) and then inverted so that only the
  // frame-start value may be used.
  task automatic send_frame(input bit mode, input bit ten, input int th);
    model_frame(mode, ten, th);
    bus.mode_max = mode;
    bus.thr_en   = ten;
    bus.thr      = th[7:0];
    for (int i = 0; i < W * H; i++) begin
      push_pix(img[i / W][i % W]);
      if (i == 0) begin
        bus.mode_max = ~mode;
        bus.thr_en   = ~ten;
        bus.thr      = ~th[7:0];
      end
      if (i == 2 * W + 2) acc22_cyc = cyc;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_scn();
    out_cnt  = 0;
    last_cnt = 0;
    dut_log.delete();
  endtask

  task automatic fill_step(input int lo, input int hi);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (c < 4) ? lo : hi;
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = v;
  endtask

  initial begin
    int t0, n;
    logic [7:0] hold_d;
    logic       hold_l;
    rst          = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b1;
    bus.mode_max = 1'b0;
    bus.thr_en   = 1'b0;
    bus.thr      = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Flat field: no edges anywhere, latency and throughput measured.
    start_scn();
    fill_const(100);
    t0 = cyc;
    fork
      send_frame(1'b0, 1'b0, 0);
      begin
        n = 0;
        while (!bus.m_valid && n < 500) begin @(negedge clk); n++; end
        chk("latency_cycles", cyc - acc22_cyc, 2);
      end
    join
    chk("throughput_cycles", cyc - t0, W * H);
    drain();
    chk("flat_count", out_cnt, NOUT);
    chk("flat_last_count", last_cnt, 1);
    chk("flat_first", dut_log[0], 0);

    // Hard vertical step 0 -> 255: only centres at cols 3 and 4 see it.
    start_scn();
    fill_step(0, 255);
    send_frame(1'b0, 1'b0, 0);
    drain();
    chk("step_c1", dut_log[0], 0);
    chk("step_c2", dut_log[1], 0);
    chk("step_c3", dut_log[2], 255);
    chk("step_c4", dut_log[3], 255);
    chk("step_c5", dut_log[4], 0);
    chk("step_r4c4", dut_log[21], 255);

    // Single bright pixel at (2,2), sum mode then max mode.
    start_scn();
    fill_const(0);
    img[2][2] = 10;
    send_frame(1'b0, 1'b0, 0);
    drain();
    chk("imp_sum_c11", dut_log[0], 20);
    chk("imp_sum_c12", dut_log[1], 20);
    start_scn();
    send_frame(1'b1, 1'b0, 0);
    drain();
    chk("imp_max_c11", dut_log[0], 10);
    chk("imp_max_c12", dut_log[1], 20);

    // Binarised steps: magnitude 80 clears threshold 50, magnitude 40 does not.
    start_scn();
    fill_step(0, 20);
    send_frame(1'b0, 1'b1, 50);
    drain();
    chk("thr80_edge", dut_log[2], 255);
    chk("thr80_flat", dut_log[0], 0);
    start_scn();
    fill_step(0, 10);
    send_frame(1'b0, 1'b1, 50);
    drain();
    chk("thr40_edge", dut_log[2], 0);
    chk("thr40_edge2", dut_log[3], 0);

    // Downstream stall of five cycles while outputs are streaming.
    start_scn();
    fill_step(0, 255);
    fork
      send_frame(1'b0, 1'b0, 0);
      begin
        n = 0;
        while (!bus.m_valid && n < 500) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 0) begin hold_d = bus.m_data; hold_l = bus.m_last; end
          chk("stall_m_valid", bus.m_valid, 1);
          chk("stall_s_ready", bus.s_ready, 0);
          chk("stall_m_data", bus.m_data, hold_d);
          chk("stall_m_last", bus.m_last, hold_l);
          @(posedge clk);
        end
        #1;
        bus.m_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", out_cnt, NOUT);
    chk("stall_c3", dut_log[2], 255);

    // Reset in the middle of a frame, then two frames back to back.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (r * 37 + c * 53 + 11) % 256;
    ignore_out = 1'b1;
    for (int i = 0; i < 3 * W + 4; i++) push_pix(img[i / W][i % W]);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_m_data", bus.m_data, 0);
    chk("midrst_m_last", bus.m_last, 0);
    ignore_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_scn();
    send_frame(1'b0, 1'b0, 0);
    send_frame(1'b1, 1'b0, 0);
    drain();
    chk("b2b_count", out_cnt, 2 * NOUT);
    chk("b2b_last_count", last_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 The module SHALL have parameter IMG_W, default 512, meaning pixels per line (minimum 3).
REQ-002 The module SHALL have parameter IMG_H, default 512, meaning lines per frame (minimum 3).
REQ-003 The module SHALL have parameter PIX_W, default 8, meaning pixel bit width.
REQ-004 The module SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The module SHALL have port s_valid  input  1  input pixel valid.
REQ-007 The module SHALL have port s_ready  output  1  input pixel accepted when s_valid && s_ready.
REQ-008 The module SHALL have port s_data  input  PIX_W  input pixel, raster order, unsigned.
REQ-009 The module SHALL have port m_valid  output  1  output pixel valid.
REQ-010 The module SHALL have port m_ready  input  1  downstream accepts when m_valid && m_ready.
REQ-011 The module SHALL have port m_data  output  PIX_W  edge magnitude.
REQ-012 The module SHALL have port m_last  output  1  high with the final output pixel of a frame.
REQ-013 The module SHALL have port mode_max  input  1  0: |Gx|+|Gy|; 1: max(|Gx|,|Gy|).
REQ-014 The module SHALL have port thr_en  input  1  binarise output.
REQ-015 The module SHALL have port thr  input  PIX_W  binarisation threshold.

Function
REQ-016 Column and row counters SHALL advance on each accepted input, column wrapping at IMG_W-1 and row wrapping at IMG_H-1 so that frames follow back-to-back without any idle.
REQ-017 Two line buffers (depth IMG_W, width PIX_W) plus a 3x3 shift window SHALL provide the neighbourhood; only interior centres are output, i.e. inputs at row>=2 and col>=2 yield one output each, giving (IMG_W-2)*(IMG_H-2) outputs per frame.
REQ-018 Gx SHALL be the right column minus the left column, and Gy the bottom row minus the top row, both with weights 1,2,1, computed signed in PIX_W+3 bits without overflow.
REQ-019 Magnitude SHALL be computed per mode_max in PIX_W+4 bits unsigned, then saturated to 2^PIX_W-1.
REQ-020 With thr_en=1, m_data SHALL be 2^PIX_W-1 if the saturated magnitude >= thr, else 0.
REQ-021 mode_max, thr_en and thr SHALL be registered when the first pixel (0,0) of a frame is accepted and held constant for that frame.
REQ-022 The pipeline SHALL have three stages (accept/window, gradient, magnitude/output register); latency SHALL be 2 cycles from the accepting edge to m_valid when unstalled.
REQ-023 s_ready SHALL equal !(m_valid && !m_ready); while stalled, all stages SHALL hold and m_data/m_last SHALL stay stable.
REQ-024 Throughput SHALL be one pixel per cycle with m_ready held high.
REQ-025 m_last SHALL assert only with the output centred at (IMG_H-2, IMG_W-2).

Reset
REQ-026 On rst, counters, stage valids, m_valid, m_last and m_data SHALL go to 0, and the frame-latched mode registers SHALL go to 0.
REQ-027 Line buffer contents SHALL NOT be reset; they are fully rewritten before use.
REQ-028 Reset mid-frame SHALL discard in-flight pixels; the next accepted pixel is (0,0) of a new frame.

Structure
REQ-029 Shared package sobel_pkg SHALL hold the gradient/magnitude width constants and the saturation function.
REQ-030 Sub-module sobel_line_buffer SHALL be a single-line, one-write/one-read, read-before-write RAM, instantiated twice.

Verification
REQ-031 Scenario 1: IMG_W=8, IMG_H=6, all pixels 100 -> 24 outputs, all 0, m_last only on the 24th.
REQ-032 Scenario 2: IMG_W=8, IMG_H=6, cols 0-3 = 0 and cols 4-7 = 255 -> centre cols 3 and 4 = 255 (saturated from 1020), all others 0.
REQ-033 Scenario 3: all pixels 0 except (2,2)=10 -> centre (1,2) = 20 in both modes; centre (1,1) = 20 with mode_max=0 and 10 with mode_max=1.
REQ-034 Scenario 4: step 0->20 with thr_en=1 and thr=50 -> edge outputs 255 (magnitude 80); step 0->10 -> outputs 0 (magnitude 40).
REQ-035 Scenario 5: m_ready low for 5 cycles mid-frame -> s_ready low, m_data stable, and the output sequence identical to an unstalled run.
REQ-036 Scenario 6: rst pulsed mid-frame, then two back-to-back frames -> exactly 2*(IMG_W-2)*(IMG_H-2) outputs, two m_last pulses, and no pre-reset data.
